header_feeder: RTL

//  Upstream sequencer for the hash core. Holds a 76-byte block header and a running nonce.

---
 rtl/header_feeder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/header_feeder.sv
// Sequencer feeding a double SHA-256 core: streams a stored 76-byte header plus a
// running nonce as block 0/1 words, then a block-2 pass, and flags each finished hash.
module header_feeder #(
    parameter int          ROUNDS     = 64,
    parameter int          HDR_WORDS  = 19,
    parameter logic [31:0] NONCE_STEP = 32'd1,
    parameter logic [31:0] LEN_WORD   = 32'h0000_0280
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hdr_we,
    input  logic [4:0]  hdr_addr,
    input  logic [31:0] hdr_data,
    input  logic [31:0] nonce_start,
    input  logic        start,
    input  logic        stop,
    output logic [1:0]  block,
    output logic [6:0]  select,
    output logic [31:0] msg_in,
    output logic [31:0] nonce,
    output logic        busy,
    output logic        result_valid,
    output logic        exhausted
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [6:0] LAST_SEL = 7'(ROUNDS - 1);
    localparam logic [5:0] HDR_N    = 6'(HDR_WORDS);

    state_t      state_q, state_d;
    logic [1:0]  block_q, block_d;
    logic [6:0]  select_q, select_d;
    logic [31:0] msg_q, msg_d;
    logic [31:0] nonce_q, nonce_d;
    logic        busy_q, busy_d;
    logic        rv_q, rv_d;
    logic        exh_q, exh_d;
    logic        stop_pend_q, stop_pend_d;
    logic        adv_q, adv_d;
    logic [31:0] hdr_q [HDR_WORDS];

    logic [32:0] nonce_sum;
    logic        load;
    logic [31:0] word;

    // Header RAM is deliberately not reset; writes are locked out while hashing.
    always_ff @(posedge clk) begin
        if (hdr_we && !busy_q && ({1'b0, hdr_addr} < HDR_N))
            hdr_q[hdr_addr] <= hdr_data;
    end

    always_comb begin
        state_d     = state_q;
        block_d     = block_q;
        select_d    = select_q;
        exh_d       = exh_q;
        stop_pend_d = stop_pend_q;
        rv_d        = 1'b0;
        adv_d       = 1'b0;
        load        = 1'b0;
        nonce_sum   = {1'b0, nonce_q} + {1'b0, NONCE_STEP};
        // The nonce advances one cycle after the result so result_valid sees the hashed value.
        nonce_d     = adv_q ? nonce_sum[31:0] : nonce_q;

        case (state_q)
            S_RUN: begin
                load = 1'b1;
                if (stop) stop_pend_d = 1'b1;
                if (select_q == LAST_SEL) begin
                    select_d = 7'd0;
                    if (block_q == 2'd2) begin
                        block_d = 2'd0;
                        rv_d    = 1'b1;
                        if (nonce_sum[32]) begin
                            state_d = S_DONE;
                            exh_d   = 1'b1;
                        end else if (stop_pend_q || stop) begin
                            state_d = S_IDLE;
                        end else begin
                            adv_d = 1'b1;
                        end
                    end else begin
                        block_d = block_q + 2'd1;
                    end
                end else begin
                    select_d = select_q + 7'd1;
                end
            end
            default: begin
                if (start) begin
                    state_d     = S_RUN;
                    block_d     = 2'd0;
                    select_d    = 7'd0;
                    nonce_d     = nonce_start;
                    exh_d       = 1'b0;
                    stop_pend_d = 1'b0;
                    load        = 1'b1;
                end
            end
        endcase

        word = 32'd0;
        if (select_d < 7'd16) begin
            case (block_d)
                2'd0: word = hdr_q[{1'b0, select_d[3:0]}];
                2'd1: begin
                    case (select_d[3:0])
                        4'd0, 4'd1, 4'd2: word = hdr_q[5'd16 + {3'b0, select_d[1:0]}];
                        4'd3:             word = nonce_d;
                        4'd4:             word = 32'h8000_0000;
                        4'd15:            word = LEN_WORD;
                        default:          word = 32'd0;
                    endcase
                end
                default: word = 32'd0;
            endcase
        end
        msg_d  = load ? word : msg_q;
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            block_q     <= 2'd0;
            select_q    <= 7'd0;
            msg_q       <= 32'd0;
            nonce_q     <= 32'd0;
            busy_q      <= 1'b0;
            rv_q        <= 1'b0;
            exh_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            adv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            block_q     <= block_d;
            select_q    <= select_d;
            msg_q       <= msg_d;
            nonce_q     <= nonce_d;
            busy_q      <= busy_d;
            rv_q        <= rv_d;
            exh_q       <= exh_d;
            stop_pend_q <= stop_pend_d;
            adv_q       <= adv_d;
        end
    end

    assign block        = block_q;
    assign select       = select_q;
    assign msg_in       = msg_q;
    assign nonce        = nonce_q;
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign exhausted    = exh_q;

endmodule
